// File: rtl/ppu_pkg.sv
// Shared definitions for the PPU CPU-facing register block.
// Register indices for $2000-$2007, VRAM sequencer states, vblank timing points.
// No logic; imported by ppu_reg_ctrl and ppu_vram_seq.
package ppu_pkg;

  localparam logic [2:0] REG_PPUCTL    = 3'd0;
  localparam logic [2:0] REG_PPUMASK   = 3'd1;
  localparam logic [2:0] REG_PPUSTATUS = 3'd2;
  localparam logic [2:0] REG_OAMADDR   = 3'd3;
  localparam logic [2:0] REG_OAMDATA   = 3'd4;
  localparam logic [2:0] REG_SCROLL    = 3'd5;
  localparam logic [2:0] REG_ADDR      = 3'd6;
  localparam logic [2:0] REG_DATA      = 3'd7;

  // Scanline/dot where vblank is raised, and where the status flags drop.
  localparam logic [8:0] VBL_SET_LINE = 9'd241;
  localparam logic [8:0] VBL_CLR_LINE = 9'd261;
  localparam logic [9:0] FLAG_DOT     = 10'd1;

  typedef enum logic [1:0] {
    VIDLE  = 2'd0,
    VWRITE = 2'd1,
    VREAD  = 2'd2
  } vram_state_t;

endpackage

// File: rtl/ppu_vram_seq.sv
// VRAM access sequencer for $2007: owns the VRAM address v, the read buffer and the request FSM.
// Latency: request rises the cycle after start; returns idle the cycle after VRAM_ACK.
// Backpressure: busy while a request is outstanding; start is ignored while busy, and
// address writes arriving while busy are parked and applied on the ACK.
// Ports: start/start_we/wdata launch an access; v_wr/v_wr_hi/v_wr_dat write half of v;
// inc32 selects +32 stepping; VRAM_ACK/VRAM_RDATA complete it; v/vram_*/busy/rbuf are state.
module ppu_vram_seq
  import ppu_pkg::*;
(
  input  logic        PPU_SLOW_CLOCK,
  input  logic        RST,
  input  logic        start,
  input  logic        start_we,
  input  logic [7:0]  wdata,
  input  logic        v_wr,
  input  logic        v_wr_hi,
  input  logic [7:0]  v_wr_dat,
  input  logic        inc32,
  input  logic        VRAM_ACK,
  input  logic [7:0]  VRAM_RDATA,
  output logic [13:0] v,
  output logic [7:0]  vram_wdata,
  output logic        vram_req,
  output logic        vram_we,
  output logic        busy,
  output logic [7:0]  rbuf
);

  vram_state_t state, state_nxt;
  logic [13:0] v_pend;
  logic        pend;
  logic [13:0] v_base, v_new, v_inc;
  logic        ack;

  always_comb begin
    state_nxt = state;
    case (state)
      VIDLE:         if (start) state_nxt = start_we ? VWRITE : VREAD;
      VWRITE, VREAD: if (VRAM_ACK) state_nxt = VIDLE;
      default:       state_nxt = VIDLE;
    endcase
  end

  assign busy     = (state != VIDLE);
  assign vram_req = busy;
  assign vram_we  = (state == VWRITE);
  assign ack      = busy && VRAM_ACK;

  // A second half-write while busy must combine with the first parked half.
  assign v_base = pend ? v_pend : v;
  assign v_new  = v_wr_hi ? {v_wr_dat[5:0], v_base[7:0]} : {v_base[13:8], v_wr_dat};
  assign v_inc  = v + (inc32 ? 14'd32 : 14'd1);

  always_ff @(posedge PPU_SLOW_CLOCK or posedge RST) begin
    if (RST) begin
      state      <= VIDLE;
      v          <= '0;
      v_pend     <= '0;
      pend       <= 1'b0;
      vram_wdata <= '0;
      rbuf       <= '0;
    end else begin
      state <= state_nxt;
      if (start && !busy && start_we) vram_wdata <= wdata;
      if (ack && state == VREAD) rbuf <= VRAM_RDATA;
      // An address written by the CPU during the access wins over the auto-increment.
      if (ack) begin
        v    <= v_wr ? v_new : (pend ? v_pend : v_inc);
        pend <= 1'b0;
      end else if (v_wr) begin
        if (busy) begin
          v_pend <= v_new;
          pend   <= 1'b1;
        end else begin
          v <= v_new;
        end
      end
    end
  end

endmodule

// File: rtl/ppu_reg_ctrl.sv
// CPU register file $2000-$2007 of the PPU: control/mask, status flags, OAM port, scroll, VRAM port.
// Latency: CPUDO and register copies update one cycle after CPU_STB; NMI follows flags combinationally.
// Backpressure: CPU_BUSY while a $2007 access is outstanding; $2007 strobes then are dropped.
// Ports: CPU side (CPU_STB/CPUA/RW/CPUDI/CPUDO/CPU_BUSY), renderer (PIX_X/PIX_Y/SPR0_HIT/SPR_OVF/NMI),
// register copies, OAM port (OAM_*) and VRAM request port (VRAM_*).
module ppu_reg_ctrl
  import ppu_pkg::*;
(
  input  logic        PPU_SLOW_CLOCK,
  input  logic        RST,
  input  logic        CPU_STB,
  input  logic [2:0]  CPUA,
  input  logic        RW,
  input  logic [7:0]  CPUDI,
  output logic [7:0]  CPUDO,
  output logic        CPU_BUSY,
  input  logic [9:0]  PIX_X,
  input  logic [8:0]  PIX_Y,
  input  logic        SPR0_HIT,
  input  logic        SPR_OVF,
  output logic        NMI,
  output logic [7:0]  PPUCTL_O,
  output logic [7:0]  PPUMASK_O,
  output logic [7:0]  SCROLL_X,
  output logic [7:0]  SCROLL_Y,
  output logic [7:0]  OAM_ADDR,
  output logic [7:0]  OAM_WDATA,
  output logic        OAM_WE,
  input  logic [7:0]  OAM_RDATA,
  output logic [13:0] VRAM_ADDR,
  output logic [7:0]  VRAM_WDATA,
  output logic        VRAM_REQ,
  output logic        VRAM_WE,
  input  logic        VRAM_ACK,
  input  logic [7:0]  VRAM_RDATA
);

  logic       w, vblank, spr0, ovf;
  logic       wr, rd, status_rd, data_acc;
  logic       vbl_set_dot, vbl_clr_dot;
  logic [7:0] rbuf, rd_dat;

  assign wr          = CPU_STB && !RW;
  assign rd          = CPU_STB && RW;
  assign status_rd   = rd && (CPUA == REG_PPUSTATUS);
  assign data_acc    = CPU_STB && (CPUA == REG_DATA) && !CPU_BUSY;
  assign vbl_set_dot = (PIX_Y == VBL_SET_LINE) && (PIX_X == FLAG_DOT);
  assign vbl_clr_dot = (PIX_Y == VBL_CLR_LINE) && (PIX_X == FLAG_DOT);
  assign NMI         = vblank && PPUCTL_O[7];

  ppu_vram_seq u_vram_seq (
    .PPU_SLOW_CLOCK (PPU_SLOW_CLOCK),
    .RST            (RST),
    .start          (data_acc),
    .start_we       (!RW),
    .wdata          (CPUDI),
    .v_wr           (wr && (CPUA == REG_ADDR)),
    .v_wr_hi        (!w),
    .v_wr_dat       (CPUDI),
    .inc32          (PPUCTL_O[2]),
    .VRAM_ACK       (VRAM_ACK),
    .VRAM_RDATA     (VRAM_RDATA),
    .v              (VRAM_ADDR),
    .vram_wdata     (VRAM_WDATA),
    .vram_req       (VRAM_REQ),
    .vram_we        (VRAM_WE),
    .busy           (CPU_BUSY),
    .rbuf           (rbuf)
  );

  always_comb begin
    rd_dat = 8'h00;
    case (CPUA)
      REG_PPUSTATUS: rd_dat = {vblank, spr0, ovf, 5'b0};
      REG_OAMDATA:   rd_dat = OAM_RDATA;
      REG_DATA:      rd_dat = rbuf;
      default:       rd_dat = 8'h00;
    endcase
  end

  always_ff @(posedge PPU_SLOW_CLOCK or posedge RST) begin
    if (RST) begin
      CPUDO     <= '0;
      PPUCTL_O  <= '0;
      PPUMASK_O <= '0;
      SCROLL_X  <= '0;
      SCROLL_Y  <= '0;
      OAM_ADDR  <= '0;
      OAM_WDATA <= '0;
      OAM_WE    <= 1'b0;
      w         <= 1'b0;
      vblank    <= 1'b0;
      spr0      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      OAM_WE <= 1'b0;
      // Post-increment happens in the cycle after the write pulse so the write lands at the old address.
      if (OAM_WE) OAM_ADDR <= OAM_ADDR + 8'd1;
      if (rd && (CPUA != REG_DATA || !CPU_BUSY)) CPUDO <= rd_dat;
      if (wr) begin
        case (CPUA)
          REG_PPUCTL:  PPUCTL_O  <= CPUDI;
          REG_PPUMASK: PPUMASK_O <= CPUDI;
          REG_OAMADDR: OAM_ADDR  <= CPUDI;
          REG_OAMDATA: begin
            OAM_WE    <= 1'b1;
            OAM_WDATA <= CPUDI;
          end
          REG_SCROLL: begin
            if (!w) SCROLL_X <= CPUDI;
            else    SCROLL_Y <= CPUDI;
            w <= !w;
          end
          REG_ADDR: w <= !w;
          default: ;
        endcase
      end
      if (status_rd) w <= 1'b0;
      if (vbl_clr_dot) begin
        vblank <= 1'b0;
        spr0   <= 1'b0;
        ovf    <= 1'b0;
      end else begin
        if (SPR0_HIT) spr0 <= 1'b1;
        if (SPR_OVF)  ovf  <= 1'b1;
        // A status read landing on the set dot both reads 0 and suppresses the set.
        if (status_rd)        vblank <= 1'b0;
        else if (vbl_set_dot) vblank <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ppu_reg_ctrl.sv
module tb_ppu_reg_ctrl;
  import ppu_pkg::*;

  logic        PPU_SLOW_CLOCK = 1'b0;
  logic        RST = 1'b1;
  logic        CPU_STB = 1'b0;
  logic [2:0]  CPUA = '0;
  logic        RW = 1'b0;
  logic [7:0]  CPUDI = '0;
  logic [7:0]  CPUDO;
  logic        CPU_BUSY;
  logic [9:0]  PIX_X = '0;
  logic [8:0]  PIX_Y = '0;
  logic        SPR0_HIT = 1'b0;
  logic        SPR_OVF = 1'b0;
  logic        NMI;
  logic [7:0]  PPUCTL_O, PPUMASK_O, SCROLL_X, SCROLL_Y, OAM_ADDR, OAM_WDATA;
  logic        OAM_WE;
  logic [7:0]  OAM_RDATA = '0;
  logic [13:0] VRAM_ADDR;
  logic [7:0]  VRAM_WDATA;
  logic        VRAM_REQ, VRAM_WE;
  logic        VRAM_ACK = 1'b0;
  logic [7:0]  VRAM_RDATA = '0;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  always #5 PPU_SLOW_CLOCK = ~PPU_SLOW_CLOCK;

  ppu_reg_ctrl dut (
    .PPU_SLOW_CLOCK(PPU_SLOW_CLOCK), .RST(RST), .CPU_STB(CPU_STB), .CPUA(CPUA), .RW(RW),
    .CPUDI(CPUDI), .CPUDO(CPUDO), .CPU_BUSY(CPU_BUSY), .PIX_X(PIX_X), .PIX_Y(PIX_Y),
    .SPR0_HIT(SPR0_HIT), .SPR_OVF(SPR_OVF), .NMI(NMI), .PPUCTL_O(PPUCTL_O),
    .PPUMASK_O(PPUMASK_O), .SCROLL_X(SCROLL_X), .SCROLL_Y(SCROLL_Y), .OAM_ADDR(OAM_ADDR),
    .OAM_WDATA(OAM_WDATA), .OAM_WE(OAM_WE), .OAM_RDATA(OAM_RDATA), .VRAM_ADDR(VRAM_ADDR),
    .VRAM_WDATA(VRAM_WDATA), .VRAM_REQ(VRAM_REQ), .VRAM_WE(VRAM_WE), .VRAM_ACK(VRAM_ACK),
    .VRAM_RDATA(VRAM_RDATA)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One CPU strobe driven between falling edges; returns at the falling edge after it was taken.
  task automatic cpu(input logic [2:0] a, input logic rw, input logic [7:0] d);
    @(negedge PPU_SLOW_CLOCK);
    CPU_STB = 1'b1; CPUA = a; RW = rw; CPUDI = d;
    @(negedge PPU_SLOW_CLOCK);
    CPU_STB = 1'b0;
  endtask

  task automatic cpu_rd(input logic [2:0] a, input logic [7:0] exp, input string tag);
    logic [7:0] e;
    exp_q.push_back(exp);
    cpu(a, 1'b1, 8'h00);
    e = exp_q.pop_front();
    chk(tag, {8'h00, CPUDO}, {8'h00, e});
  endtask

  // Counts busy cycles, raising ACK in the n-th one; also counts any busy after the ACK.
  task automatic do_ack(input int n, input logic [7:0] rdat, output int bcnt);
    bcnt = 0;
    for (int i = 0; i < n; i++) begin
      if (CPU_BUSY) bcnt++;
      if (i == n - 1) begin
        VRAM_ACK = 1'b1;
        VRAM_RDATA = rdat;
      end
      @(negedge PPU_SLOW_CLOCK);
    end
    VRAM_ACK = 1'b0;
    if (CPU_BUSY) bcnt++;
  endtask

  task automatic set_pix(input logic [8:0] y, input logic [9:0] x);
    @(negedge PPU_SLOW_CLOCK);
    PIX_Y = y; PIX_X = x;
  endtask

  initial begin
    int  bc;
    logic nmi_seen;

    // Reset state
    repeat (3) @(negedge PPU_SLOW_CLOCK);
    chk("rst_cpudo", {8'h0, CPUDO}, 16'h0);
    chk("rst_busy", {15'h0, CPU_BUSY}, 16'h0);
    chk("rst_nmi", {15'h0, NMI}, 16'h0);
    chk("rst_vaddr", {2'b0, VRAM_ADDR}, 16'h0);
    chk("rst_oamaddr", {8'h0, OAM_ADDR}, 16'h0);
    RST = 1'b0;

    // $2006/$2006/$2007 write with ACK in the third busy cycle
    cpu(REG_ADDR, 1'b0, 8'h21);
    cpu(REG_ADDR, 1'b0, 8'h08);
    chk("v_load", {2'b0, VRAM_ADDR}, 16'h2108);
    cpu(REG_DATA, 1'b0, 8'hAB);
    chk("wr_req", {15'h0, VRAM_REQ}, 16'h1);
    chk("wr_we", {15'h0, VRAM_WE}, 16'h1);
    chk("wr_addr", {2'b0, VRAM_ADDR}, 16'h2108);
    chk("wr_wdata", {8'h0, VRAM_WDATA}, 16'h00AB);
    do_ack(3, 8'h00, bc);
    chk("busy_cycles", bc[15:0], 16'd3);
    chk("v_inc1", {2'b0, VRAM_ADDR}, 16'h2109);

    // Dropped $2007 and deferred $2006 while busy
    cpu(REG_DATA, 1'b0, 8'h77);
    cpu(REG_DATA, 1'b0, 8'h99);
    chk("drop_wdata", {8'h0, VRAM_WDATA}, 16'h0077);
    cpu(REG_ADDR, 1'b0, 8'h3F);
    chk("defer_addr", {2'b0, VRAM_ADDR}, 16'h2109);
    do_ack(1, 8'h00, bc);
    chk("defer_apply", {2'b0, VRAM_ADDR}, 16'h3F09);
    cpu(REG_ADDR, 1'b0, 8'hF0);
    chk("v_3ff0", {2'b0, VRAM_ADDR}, 16'h3FF0);

    // +32 increment wrapping past 2^14
    cpu(REG_PPUCTL, 1'b0, 8'h04);
    chk("ppuctl", {8'h0, PPUCTL_O}, 16'h0004);
    cpu(REG_DATA, 1'b0, 8'h55);
    do_ack(2, 8'h00, bc);
    chk("v_wrap", {2'b0, VRAM_ADDR}, 16'h0010);

    // Write-only registers read as zero
    cpu(REG_PPUMASK, 1'b0, 8'h1E);
    chk("ppumask", {8'h0, PPUMASK_O}, 16'h001E);
    cpu_rd(REG_PPUMASK, 8'h00, "rd_mask");
    cpu_rd(REG_PPUCTL, 8'h00, "rd_ctl");

    // Buffered $2007 reads
    cpu(REG_PPUCTL, 1'b0, 8'h00);
    cpu(REG_ADDR, 1'b0, 8'h10);
    cpu(REG_ADDR, 1'b0, 8'h00);
    cpu_rd(REG_DATA, 8'h00, "rd_buf0");
    chk("rd_we", {15'h0, VRAM_WE}, 16'h0);
    chk("rd_req", {15'h0, VRAM_REQ}, 16'h1);
    do_ack(2, 8'h11, bc);
    cpu_rd(REG_DATA, 8'h11, "rd_buf1");
    do_ack(2, 8'h22, bc);
    chk("rd_vaddr", {2'b0, VRAM_ADDR}, 16'h1002);

    // OAM port
    cpu(REG_OAMADDR, 1'b0, 8'hFF);
    chk("oam_addr", {8'h0, OAM_ADDR}, 16'h00FF);
    cpu(REG_OAMDATA, 1'b0, 8'h5A);
    chk("oam_we", {15'h0, OAM_WE}, 16'h1);
    chk("oam_we_addr", {8'h0, OAM_ADDR}, 16'h00FF);
    chk("oam_wdata", {8'h0, OAM_WDATA}, 16'h005A);
    @(negedge PPU_SLOW_CLOCK);
    chk("oam_we_off", {15'h0, OAM_WE}, 16'h0);
    chk("oam_wrap", {8'h0, OAM_ADDR}, 16'h0000);
    OAM_RDATA = 8'hC3;
    cpu_rd(REG_OAMDATA, 8'hC3, "oam_rd");
    chk("oam_rd_noinc", {8'h0, OAM_ADDR}, 16'h0000);

    // Scroll via write toggle
    cpu(REG_SCROLL, 1'b0, 8'h12);
    cpu(REG_SCROLL, 1'b0, 8'h34);
    chk("scroll_x", {8'h0, SCROLL_X}, 16'h0012);
    chk("scroll_y", {8'h0, SCROLL_Y}, 16'h0034);

    // Vblank / NMI; status read clears vblank and w
    cpu(REG_PPUCTL, 1'b0, 8'h80);
    cpu(REG_SCROLL, 1'b0, 8'hAA);
    set_pix(9'd241, 10'd1);
    set_pix(9'd241, 10'd2);
    chk("nmi_set", {15'h0, NMI}, 16'h1);
    cpu_rd(REG_PPUSTATUS, 8'h80, "status_vbl");
    chk("nmi_clr", {15'h0, NMI}, 16'h0);
    cpu(REG_SCROLL, 1'b0, 8'h56);
    chk("w_cleared", {8'h0, SCROLL_X}, 16'h0056);
    cpu(REG_SCROLL, 1'b0, 8'h00);

    // Sticky sprite flags until line 261
    @(negedge PPU_SLOW_CLOCK);
    SPR0_HIT = 1'b1; SPR_OVF = 1'b1;
    @(negedge PPU_SLOW_CLOCK);
    SPR0_HIT = 1'b0; SPR_OVF = 1'b0;
    cpu_rd(REG_PPUSTATUS, 8'h60, "status_spr");
    cpu_rd(REG_PPUSTATUS, 8'h60, "status_sticky");
    set_pix(9'd261, 10'd1);
    set_pix(9'd261, 10'd2);
    cpu_rd(REG_PPUSTATUS, 8'h00, "status_261");

    // Status read on the vblank set dot suppresses the frame's vblank
    @(negedge PPU_SLOW_CLOCK);
    PIX_Y = 9'd241; PIX_X = 10'd1;
    CPU_STB = 1'b1; CPUA = REG_PPUSTATUS; RW = 1'b1;
    exp_q.push_back(8'h00);
    @(negedge PPU_SLOW_CLOCK);
    CPU_STB = 1'b0; PIX_X = 10'd2;
    chk("race_rd", {8'h0, CPUDO}, {8'h0, exp_q.pop_front()});
    nmi_seen = NMI;
    for (int y = 242; y <= 260; y++) begin
      set_pix(y[8:0], 10'd1);
      if (NMI) nmi_seen = 1'b1;
    end
    chk("race_nmi", {15'h0, nmi_seen}, 16'h0);
    cpu_rd(REG_PPUSTATUS, 8'h00, "race_status");

    // Asynchronous reset in the middle of a VRAM read
    cpu(REG_DATA, 1'b1, 8'h00);
    chk("vread_req", {15'h0, VRAM_REQ}, 16'h1);
    #2 RST = 1'b1;
    #1;
    chk("arst_req", {15'h0, VRAM_REQ}, 16'h0);
    chk("arst_busy", {15'h0, CPU_BUSY}, 16'h0);
    chk("arst_ctl", {8'h0, PPUCTL_O}, 16'h0);
    chk("arst_vaddr", {2'b0, VRAM_ADDR}, 16'h0);
    chk("arst_scroll", {8'h0, SCROLL_Y}, 16'h0);
    @(negedge PPU_SLOW_CLOCK);
    RST = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ppu_reg_ctrl.md
PPU_REG_CTRL -- requirements
Module: ppu_reg_ctrl

Interface
REQ-001 SHALL have one clock, PPU_SLOW_CLOCK; reset is RST, asynchronous, active-high.
REQ-002 Ports, in order (name  direction  width  meaning):
- PPU_SLOW_CLOCK  in  1  PPU clock, rising edge.
- RST  in  1  async active-high reset.
- CPU_STB  in  1  one-cycle CPU access strobe.
- CPUA  in  3  register select, $2000-$2007.
- RW  in  1  1 = read, 0 = write.
- CPUDI  in  8  CPU write data.
- CPUDO  out  8  CPU read data, registered.
- CPU_BUSY  out  1  $2007 VRAM op pending.
- PIX_X  in  10  renderer pixel column.
- PIX_Y  in  9  renderer scanline.
- SPR0_HIT  in  1  sprite-0 hit pulse.
- SPR_OVF  in  1  sprite overflow pulse.
- NMI  out  1  level interrupt.
- PPUCTL_O  out  8  PPUCTL copy.
- PPUMASK_O  out  8  PPUMASK copy.
- SCROLL_X  out  8  scroll X.
- SCROLL_Y  out  8  scroll Y.
- OAM_ADDR  out  8  OAM pointer.
- OAM_WDATA  out  8  OAM write data.
- OAM_WE  out  1  OAM write pulse.
- OAM_RDATA  in  8  OAM read data at OAM_ADDR.
- VRAM_ADDR  out  14  VRAM address.
- VRAM_WDATA  out  8  VRAM write data.
- VRAM_REQ  out  1  VRAM request.
- VRAM_WE  out  1  1 = write request.
- VRAM_ACK  in  1  one-cycle completion.
- VRAM_RDATA  in  8  read data, valid with ACK.

Function
REQ-003 Access SHALL be decoded only on CPU_STB; CPUDO SHALL update the cycle after a read strobe and hold until the next one.
REQ-004 $2000/$2001 writes SHALL load PPUCTL_O/PPUMASK_O; reads of write-only registers ($2000, $2001, $2003, $2005, $2006) SHALL return 0.
REQ-005 Shared write toggle w: $2005 write with w=0 loads SCROLL_X, with w=1 loads SCROLL_Y; $2006 write with w=0 loads v[13:8]=CPUDI[5:0], with w=1 loads v[7:0]; each such write SHALL flip w.
REQ-006 $2002 read SHALL return {vblank, spr0, ovf, 5'b0}, then clear vblank and w.
REQ-007 vblank SHALL set at PIX_Y=241, PIX_X=1; vblank, spr0, ovf SHALL clear at PIX_Y=261, PIX_X=1.
REQ-008 A $2002 read strobe on the vblank-set cycle SHALL return bit7=0 and vblank SHALL stay clear that frame.
REQ-009 spr0/ovf SHALL be sticky on their input pulses until the REQ-007 clear.
REQ-010 NMI SHALL equal vblank AND PPUCTL_O[7]; setting bit7 while vblank=1 SHALL raise NMI next cycle.
REQ-011 $2003 write SHALL load OAM_ADDR; $2004 write SHALL pulse OAM_WE one cycle with OAM_WDATA=CPUDI, then OAM_ADDR+1 (255 wraps to 0); $2004 read SHALL return OAM_RDATA without increment.
REQ-012 VRAM FSM states VIDLE, VWRITE, VREAD; $2007 write VIDLE->VWRITE, $2007 read VIDLE->VREAD; VRAM_REQ and CPU_BUSY high in VWRITE/VREAD; on VRAM_ACK return to VIDLE.
REQ-013 VRAM_ADDR SHALL equal v, held stable while VRAM_REQ is high.
REQ-014 On ACK, v SHALL increment by 32 when PPUCTL_O[2]=1, else by 1, modulo 2^14.
REQ-015 $2007 read SHALL return the read buffer, then on ACK load the buffer from VRAM_RDATA; the buffer applies to all addresses, palette included.
REQ-016 A $2007 strobe while CPU_BUSY=1 SHALL be dropped with no state change; other registers SHALL stay accessible.
REQ-017 A $2006 write while busy SHALL update v only after the ACK.

Reset
REQ-018 On RST, all registers, v, w, buffer and flags SHALL clear to 0, state SHALL go to VIDLE, and every output SHALL be 0, mid-transaction included.

Structure
REQ-019 Package ppu_pkg SHALL hold register index constants, the VRAM FSM state enum, and scanline constants 241/261.
REQ-020 The VRAM FSM plus v-increment logic SHALL be one sub-module, ppu_vram_seq.

Verification
REQ-021 $2006 0x21, $2006 0x08, $2007 0xAB, ACK after 3 cycles -> VRAM_ADDR=0x2108, VRAM_WE=1, BUSY 3 cycles, v=0x2109.
REQ-022 PPUCTL=0x04, v=0x3FF0, $2007 write+ACK -> v=0x0010 (wrap).
REQ-023 Reach PIX_Y=241 PIX_X=1 with PPUCTL=0x80 -> NMI=1; $2002 read -> 0x80, NMI=0, w=0.
REQ-024 $2002 read on the set cycle -> CPUDO bit7=0, NMI stays 0 to line 261.
REQ-025 OAM_ADDR=0xFF, $2004 write 0x5A -> OAM_WE pulse at 0xFF, OAM_ADDR=0x00.
REQ-026 Two $2007 reads (RDATA 0x11, then 0x22) -> CPUDO 0x00 then 0x11; RST mid-VREAD -> VRAM_REQ=0 immediately.
